// File: rtl/score_keeper.sv
// score_keeper
// Turns the collision checker's Score pulse and Over level into the visible
// game score: a saturating 3-digit BCD score, a high-score register, a freeze
// of the score on game over, and three active-low 7-segment digits that
// blink while the game is over.
//
// Ports:
//   clk       system clock, rising edge
//   RST       asynchronous active-high reset (clears high score too)
//   Restart   synchronous new-game request (keeps high score)
//   Score     score event; only its rising edge counts
//   Over      game-over level
//   showHigh  1 = display high score, 0 = display current score
//   count     current score, packed BCD {hundreds, tens, ones}
//   high      high score, packed BCD
//   newHigh   the last game set a new high score
//   dead      FSM is in DEAD
//   HEX0..2   ones/tens/hundreds digits, active-low, bit order gfedcba
module score_keeper #(
   parameter int BLINK_DIV = 8192
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        Restart,
   input  logic        Score,
   input  logic        Over,
   input  logic        showHigh,
   output logic [11:0] count,
   output logic [11:0] high,
   output logic        newHigh,
   output logic        dead,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2
);

   localparam int CW = $clog2(BLINK_DIV);
   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

   localparam logic [0:0] PLAY = 1'b0;
   localparam logic [0:0] DEAD = 1'b1;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   logic [0:0]    state_reg, state_next;
   logic [11:0]   count_reg, count_next;
   logic [11:0]   high_reg, high_next;
   logic          new_high_reg, new_high_next;
   logic          score_prev_reg;
   logic [CW-1:0] blink_cnt_reg, blink_cnt_next;
   logic          blank_reg, blank_next;   // 1 = blank half of the blink

   logic          score_edge;
   logic [11:0]   count_inc;

   assign score_edge = Score & ~score_prev_reg;

   // BCD increment with ripple carry; holds at 999.
   always_comb begin
      count_inc = count_reg;
      if (count_reg == 12'h999) begin
         count_inc = count_reg;
      end else if (count_reg[3:0] != 4'd9) begin
         count_inc = {count_reg[11:4], count_reg[3:0] + 4'd1};
      end else if (count_reg[7:4] != 4'd9) begin
         count_inc = {count_reg[11:8], count_reg[7:4] + 4'd1, 4'd0};
      end else begin
         count_inc = {count_reg[11:8] + 4'd1, 8'h00};
      end
   end

   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      high_next      = high_reg;
      new_high_next  = new_high_reg;
      blink_cnt_next = blink_cnt_reg;
      blank_next     = blank_reg;
      case (state_reg)
         PLAY: begin
            if (Restart) begin
               count_next    = 12'h000;
               new_high_next = 1'b0;
            end else if (Over) begin
               // A score edge in this same cycle is dropped on purpose.
               state_next     = DEAD;
               blink_cnt_next = '0;
               blank_next     = 1'b0;
               // Packed BCD orders correctly as an unsigned binary value.
               if (count_reg > high_reg) begin
                  high_next     = count_reg;
                  new_high_next = 1'b1;
               end
            end else if (score_edge) begin
               count_next = count_inc;
            end
         end
         DEAD: begin
            if (Restart) begin
               count_next     = 12'h000;
               new_high_next  = 1'b0;
               state_next     = PLAY;
               blink_cnt_next = '0;
               blank_next     = 1'b0;
            end else if (blink_cnt_reg == BLINK_LAST) begin
               blink_cnt_next = '0;
               blank_next     = ~blank_reg;
            end else begin
               blink_cnt_next = blink_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = PLAY;
         end
      endcase
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_reg      <= PLAY;
         count_reg      <= 12'h000;
         high_reg       <= 12'h000;
         new_high_reg   <= 1'b0;
         score_prev_reg <= 1'b0;
         blink_cnt_reg  <= '0;
         blank_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         count_reg      <= count_next;
         high_reg       <= high_next;
         new_high_reg   <= new_high_next;
         score_prev_reg <= Score;
         blink_cnt_reg  <= blink_cnt_next;
         blank_reg      <= blank_next;
      end
   end

   assign count   = count_reg;
   assign high    = high_reg;
   assign newHigh = new_high_reg;
   assign dead    = (state_reg == DEAD);

   // ---------------------------------------------------------------
   // Display path: purely combinational from registers and showHigh.
   // ---------------------------------------------------------------
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'b1000000;
         4'd1:    seg_of = 7'b1111001;
         4'd2:    seg_of = 7'b0100100;
         4'd3:    seg_of = 7'b0110000;
         4'd4:    seg_of = 7'b0011001;
         4'd5:    seg_of = 7'b0010010;
         4'd6:    seg_of = 7'b0000010;
         4'd7:    seg_of = 7'b1111000;
         4'd8:    seg_of = 7'b0000000;
         4'd9:    seg_of = 7'b0010000;
         default: seg_of = SEG_OFF;
      endcase
   endfunction

   logic [2:0][3:0] digit;
   logic [2:0][6:0] seg;
   logic            blanked;

   assign digit   = showHigh ? high_reg : count_reg;
   assign blanked = (state_reg == DEAD) && blank_reg;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_seg
         assign seg[gi] = seg_of(digit[gi]);
      end
   endgenerate

   // Leading-zero blanking on hundreds and tens; ones always shown.
   assign HEX2 = (blanked || digit[2] == 4'd0) ? SEG_OFF : seg[2];
   assign HEX1 = (blanked || (digit[2] == 4'd0 && digit[1] == 4'd0)) ? SEG_OFF : seg[1];
   assign HEX0 = blanked ? SEG_OFF : seg[0];

endmodule

// File: doc/score_keeper.md
# score_keeper

Consumes the `Score` pulse and `Over` flag produced by the collision/score checker and turns them into the visible game score. It keeps a saturating 3-digit BCD score and a high-score register, freezes the score on game over, and drives three active-low 7-segment digits (HEX2..HEX0). While the game is over, the digits blink. The block sits between the collision checker and the board HEX outputs.

## Interface
- `BLINK_DIV`, default 8192: clock cycles per blink half-period while dead. Must be ≥ 2.
- `clk` in 1: system clock, rising edge.
- `RST` in 1: asynchronous, active-high reset. Clears everything, including the high score.
- `Restart` in 1: synchronous new-game request. Clears the current score and keeps the high score.
- `Score` in 1: score event from the checker. Only the 0→1 transition counts.
- `Over` in 1: game-over level from the checker.
- `showHigh` in 1: 1 displays the high score, 0 displays the current score.
- `count` out 12: current score, packed BCD {hundreds, tens, ones}.
- `high` out 12: high score, packed BCD.
- `newHigh` out 1: the last game set a new high score.
- `dead` out 1: FSM is in DEAD.
- `HEX0`, `HEX1`, `HEX2` out 7 each: ones, tens and hundreds digits, active-low, bit order gfedcba.

## Operation
- **Reset values (RST=1, asynchronous):**
  - State PLAY; `count`=0x000, `high`=0x000, `newHigh`=0, `dead`=0.
  - Score-edge register 0; blink counter 0; blink phase visible.
  - `HEX0`=1000000; `HEX1` and `HEX2` = 1111111.
- **Edge detect:**
  - `scoreEdge` = `Score` & ~`scorePrev`.
  - `scorePrev` <= `Score` every cycle, in every state.
  - A `Score` level held high counts exactly once.
- **FSM priority per cycle:** `Restart` > `Over` > `scoreEdge`.
- **PLAY:**
  - `Restart`: `count`<=0, `newHigh`<=0, stay in PLAY.
  - Else if `Over`=1: go to DEAD. A `scoreEdge` in the same cycle is dropped.
    - If `count` > `high`: `high`<=`count` and `newHigh`<=1. Packed BCD compares correctly as unsigned 12-bit.
    - If equal or less: `high` and `newHigh` are unchanged.
    - Blink counter <=0, phase <= visible.
  - Else if `scoreEdge`: BCD increment of `count`, ones → tens → hundreds carry.
    - 0x009→0x010, 0x099→0x100.
    - Saturates at 0x999; further edges leave it unchanged.
- **DEAD:**
  - `count` and `high` are frozen; `Score` edges are ignored.
  - The blink counter runs 0..BLINK_DIV-1. On reaching BLINK_DIV-1 it wraps to 0 and the phase toggles.
  - `Restart`: `count`<=0, `newHigh`<=0, state <= PLAY, blink counter <=0, phase <= visible.
  - If `Over` is still 1 in the cycle after a `Restart`, the FSM re-enters DEAD. In that case `count`=0, so `high` is untouched.
- **Display (combinational from registers):**
  - Value shown: `high` if `showHigh`=1, else `count`.
  - Leading-zero blanking: `HEX2` blank when hundreds=0. `HEX1` blank when hundreds=0 and tens=0. `HEX0` is always shown.
  - Blank phase (DEAD only): all three HEX = 1111111.
  - Encoding:
    - 0 = 1000000
    - 1 = 1111001
    - 2 = 0100100
    - 3 = 0110000
    - 4 = 0011001
    - 5 = 0010010
    - 6 = 0000010
    - 7 = 1111000
    - 8 = 0000000
    - 9 = 0010000
  - Non-BCD digit values cannot occur.

## Timing
- **Score path:** `Score` rises before edge N → `count` shows the new value after edge N. Latency is 1 cycle.
- **Over path:** `Over` sampled at edge N → `dead`, `high` and `newHigh` are valid after edge N.
- **Blink:** after entering DEAD at edge N, digits are visible for edges N..N+BLINK_DIV-1 and blank from N+BLINK_DIV for BLINK_DIV cycles, then repeat.
- **Display latency:** HEX outputs follow register and `showHigh` changes in the same cycle, with no register stage.
- **RST mid-game:** takes effect immediately, without waiting for a clock edge. The first edge after deassertion behaves as PLAY with `scorePrev`=0. A `Score` already high at that edge counts once.

## Test plan
1. **Basic count:** RST, then three 1-cycle `Score` pulses → `count`=0x003, `HEX0`=0110000, `HEX1`=`HEX2`=1111111.
2. **Held Score:** `Score` held high 10 cycles from count 0x003 → `count`=0x004, one increment only. Then 96 more pulses → `count`=0x100, `HEX2`=1111001, `HEX1`=`HEX0`=1000000.
3. **Saturation:** 1005 pulses from 0 → `count`=0x999, remains 0x999.
4. **Game over, new high:** at `count`=0x005, `high`=0 and `BLINK_DIV`=4, raise `Over` together with a `Score` pulse.
   - `count` stays 0x005; after that edge `dead`=1, `high`=0x005, `newHigh`=1.
   - HEX is visible for 4 cycles, blank for 4 cycles, visible again.
   - Later `Score` pulses are ignored.
5. **Restart keeps high:**
   - `Restart` with `Over` low → `count`=0, `newHigh`=0, `dead`=0, `high`=0x005.
   - Score to 0x002, then `Over` → `high` stays 0x005, `newHigh`=0.
   - `showHigh`=1 → `HEX0`=0010010.
6. **Asynchronous reset in DEAD:** assert RST between clock edges → all outputs reach reset values before the next edge; `high`=0x000.
